mdu: RTL and testbench

//   Multiply/divide unit with architectural HI/LO registers, downstream of the GPR file.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_if.sv | 33 +++
 rtl/mdu_div_iter.sv | 80 ++++++++
 rtl/mdu.sv | 173 +++++++++++++++++
 tb/tb_mdu.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   Operation encodings (also produced by the instruction decoder), FSM state
//   encodings, datapath width and the number of restoring-division steps.
package mdu_pkg;

    localparam int WIDTH     = 32;
    localparam int DIV_STEPS = WIDTH;

    // Operation encodings carried on op together with start.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Control FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= OP_MTLO;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if -- issue-side bundle of the multiply/divide unit.
//   master (issue stage) drives : start, op, src_a, src_b, cancel
//   slave  (mdu)         drives : busy, done, hi, lo, dbg_state
//
// Handshake: start is a request strobe that the mdu samples only while
// busy==0; an op presented while busy==1 is dropped, so the issue stage must
// keep start/op/operands stable until it sees busy==0 at a clock edge.
// cancel aborts whatever is in flight and overrides start in the same cycle.
// done is a registered one-cycle pulse in the cycle after HI/LO were written.
interface mdu_if #(parameter int WIDTH = mdu_pkg::WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, hi, lo, dbg_state
    );

endinterface

// File: rtl/mdu_div_iter.sv
// mdu_div_iter -- restoring divider datapath for unsigned magnitudes.
//   clk, resetn   : clock, asynchronous active-low reset
//   load_i        : latch dividend_i/divisor_i, clear remainder and step counter
//   step_i        : perform one restoring step
//   dividend_i    : unsigned dividend magnitude
//   divisor_i     : unsigned divisor magnitude
//   quot_o        : quotient (valid after DIV_STEPS steps)
//   rem_o         : remainder (valid after DIV_STEPS steps)
//   last_step_o   : the step counter is on its final value
module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = mdu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_step_o
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift the next dividend bit into the partial remainder; one extra bit
    // keeps the trial value exact before the compare.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial  = {rem_q, quot_q[WIDTH-1]};
        diff   = trial - {1'b0, dvs_q};
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            rem_d  = '0;
            quot_d = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
        end else if (step_i) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d  = diff[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot_o      = quot_q;
    assign rem_o       = rem_q;
    assign last_step_o = (cnt_q == CNT_W'(DIV_STEPS - 1));

endmodule

// File: rtl/mdu.sv
// mdu -- multiply/divide unit with architectural HI/LO registers.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : start/op/src_a/src_b/cancel in; busy/done/hi/lo/dbg_state out
// MULT/MULTU occupy one cycle, DIV/DIVU 33 cycles (32 restoring steps plus a
// sign fix-up cycle), MTHI/MTLO write in the issue cycle without going busy.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = mdu_pkg::WIDTH
) (
    input  logic  clk,
    input  logic  resetn,
    mdu_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mul_signed_q, mul_signed_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             div_load, div_step, div_last;
    logic             div_signed;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] quot, rem;
    logic [2*WIDTH-1:0] product;

    // Magnitudes for the divider come straight from the issue operands so
    // they are loaded on the same edge the op is accepted. The magnitude of
    // the most negative value is itself as an unsigned number, which is what
    // makes 0x8000_0000 / -1 wrap to 0x8000_0000.
    assign div_signed   = (bus.op == OP_DIV);
    assign dividend_mag = (div_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign divisor_mag  = (div_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    // Sign- or zero-extend to the full product width; the low 2*WIDTH bits of
    // the extended product are the correct signed or unsigned result.
    always_comb begin
        if (mul_signed_q) begin
            product = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            product = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        mul_signed_d = mul_signed_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        div_zero_d   = div_zero_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        div_load     = 1'b0;
        div_step     = 1'b0;

        // cancel wins over everything, including a start in IDLE and the
        // result write in FIX.
        if (bus.cancel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && op_is_valid(bus.op)) begin
                        case (bus.op)
                            OP_MTHI: begin
                                hi_d   = bus.src_a;
                                done_d = 1'b1;
                            end
                            OP_MTLO: begin
                                lo_d   = bus.src_a;
                                done_d = 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                a_d          = bus.src_a;
                                b_d          = bus.src_b;
                                mul_signed_d = (bus.op == OP_MULT);
                                state_d      = ST_MUL;
                            end
                            default: begin
                                // DIV / DIVU; a_q keeps the raw dividend for
                                // the divide-by-zero result.
                                a_d        = bus.src_a;
                                b_d        = bus.src_b;
                                q_neg_d    = div_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                                r_neg_d    = div_signed && bus.src_a[WIDTH-1];
                                div_zero_d = (bus.src_b == '0);
                                div_load   = 1'b1;
                                state_d    = ST_DIV;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end
                ST_DIV: begin
                    div_step = 1'b1;
                    if (div_last) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (div_zero_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = r_neg_q ? -rem : rem;
                        lo_d = q_neg_q ? -quot : quot;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            div_zero_q   <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mul_signed_q <= mul_signed_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            div_zero_q   <= div_zero_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            done_q       <= done_d;
        end
    end

    mdu_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (dividend_mag),
        .divisor_i   (divisor_mag),
        .quot_o      (quot),
        .rem_o       (rem),
        .last_step_o (div_last)
    );

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed bench for the multiply/divide unit.
module tb_mdu;
    import mdu_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;

    mdu_if bus ();

    mdu dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_mul(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        tick();
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    // Count busy cycles (bounded) then check the result and the done pulse.
    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        issue(op, a, b);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            check({tag, "_no_early_done"}, 64'(bus.done), 64'd0);
            cycles++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        tick();
        check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.src_a  = '0;
        bus.src_b  = '0;
        bus.cancel = 1'b0;

        #23;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        resetn = 1'b1;
        tick();

        // Multiply
        run_mul("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_mul("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        run_mul("mult_pos", OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

        // Divide
        run_div("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_div("div_mixed", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_div("div_zero_s", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        run_div("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

        // Cancel at DIV cycle 20, then a new op is accepted right away
        issue(OP_DIV, 32'd100, 32'd7);
        check("cancel_in_div", 64'(bus.dbg_state), 64'(ST_DIV));
        for (int i = 1; i < 20; i++) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_done", 64'(bus.done), 64'd0);
        check("cancel_hi", 64'(bus.hi), 64'd5);
        check("cancel_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        run_mul("after_cancel", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        // Cancel in the FIX cycle discards the result
        issue(OP_DIVU, 32'd9, 32'd4);
        for (int i = 0; i < 32; i++) tick();
        check("fix_state", 64'(bus.dbg_state), 64'(ST_FIX));
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("fix_cancel_busy", 64'(bus.busy), 64'd0);
        check("fix_cancel_done", 64'(bus.done), 64'd0);
        check("fix_cancel_hi", 64'(bus.hi), 64'd0);
        check("fix_cancel_lo", 64'(bus.lo), 64'd42);

        // cancel beats an MTHI start
        bus.cancel = 1'b1;
        issue(OP_MTHI, 32'hABCD, 32'd0);
        bus.cancel = 1'b0;
        check("mthi_cancel_hi", 64'(bus.hi), 64'd0);
        check("mthi_cancel_done", 64'(bus.done), 64'd0);

        // Undefined op is a no-op
        issue(3'd6, 32'h1111, 32'h2222);
        check("undef_busy", 64'(bus.busy), 64'd0);
        check("undef_done", 64'(bus.done), 64'd0);
        check("undef_lo", 64'(bus.lo), 64'd42);

        // MTHI then MTLO back-to-back
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.src_a = 32'h1234;
        tick();
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_done", 64'(bus.done), 64'd1);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        bus.op    = OP_MTLO;
        bus.src_a = 32'h5678;
        tick();
        bus.start = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'h5678);
        check("mtlo_hi_kept", 64'(bus.hi), 64'h1234);
        check("mtlo_done", 64'(bus.done), 64'd1);
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        tick();
        check("mtlo_done_end", 64'(bus.done), 64'd0);

        // start while busy is ignored
        issue(OP_DIVU, 32'd100, 32'd7);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.src_a = 32'hDEAD;
        for (int i = 0; i < 5; i++) tick();
        bus.start = 1'b0;
        begin
            int cycles;
            cycles = 0;
            while (bus.busy && cycles < 100) begin
                cycles++;
                tick();
            end
            check("ignore_cycles", 64'(cycles + 5), 64'd33);
        end
        check("ignore_hi", 64'(bus.hi), 64'd2);
        check("ignore_lo", 64'(bus.lo), 64'd14);

        // Asynchronous reset in DIV cycle 10
        issue(OP_DIV, 32'd1000, 32'd3);
        for (int i = 1; i < 10; i++) tick();
        check("rst_mid_busy_before", 64'(bus.busy), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_hi", 64'(bus.hi), 64'd0);
        check("rst_mid_lo", 64'(bus.lo), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        #3;
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("rst_after_hi", 64'(bus.hi), 64'd0);
        check("rst_after_lo", 64'(bus.lo), 64'd0);
        check("rst_after_busy", 64'(bus.busy), 64'd0);
        check("rst_after_done", 64'(bus.done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
